// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests the icache, consults the branch predictor and pushes to the IQ.
// Define FETCH_RAS_EN to add a 4-entry circular return-address stack for call/return prediction.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        hci_rdy,
  output logic        if_req_valid,
  output logic [16:0] if_req_addr,
  input  logic        if_resp_valid,
  input  logic [31:0] if_resp_inst,
  output logic [16:0] q_address,
  input  logic        q_take,
  input  logic        iq_full,
  output logic        iq_push,
  output logic [31:0] iq_inst,
  output logic [16:0] iq_pc,
  output logic        iq_pred_take,
  output logic [16:0] iq_pred_pc,
  input  logic        redirect_en,
  input  logic [16:0] redirect_pc
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_STALL = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state_q;
  logic [16:0] pc_q;
  logic [31:0] inst_buf_q;
  logic        req_vld_q;
  logic        push_q;
  logic [31:0] iq_inst_q;
  logic [16:0] iq_pc_q;
  logic        iq_take_q;
  logic [16:0] iq_pred_q;

  logic [6:0]  opcode;
  logic [16:0] imm_b;
  logic [16:0] imm_j;
  logic [16:0] pc_plus4;
  logic [16:0] next_pc_d;
  logic        pred_take_d;
  logic        stall_d;

  assign opcode   = inst_buf_q[6:0];
  assign imm_b    = {{4{inst_buf_q[31]}}, inst_buf_q[31], inst_buf_q[7],
                     inst_buf_q[30:25], inst_buf_q[11:8], 1'b0};
  // J immediate is 21 bits; its low 17 bits are all a 17-bit PC can use.
  assign imm_j    = {inst_buf_q[16:12], inst_buf_q[20], inst_buf_q[30:21], 1'b0};
  assign pc_plus4 = pc_q + 17'd4;

`ifdef FETCH_RAS_EN
  logic [16:0] ras_q [4];
  logic [1:0]  ras_top_q;
  logic [2:0]  ras_cnt_q;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [11:0] imm_i;
  logic        rd_link;
  logic        rs1_link;
  logic        ras_call;
  logic        ras_ret;
  logic        issue_fire;

  assign rd         = inst_buf_q[11:7];
  assign rs1        = inst_buf_q[19:15];
  assign imm_i      = inst_buf_q[31:20];
  assign rd_link    = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link   = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign ras_call   = ((opcode == OP_JAL) || (opcode == OP_JALR)) && rd_link;
  assign ras_ret    = (opcode == OP_JALR) && (rd == 5'd0) && rs1_link &&
                      (imm_i == 12'd0) && (ras_cnt_q != 3'd0);
  assign issue_fire = hci_rdy && !redirect_en && (state_q == S_ISSUE) && !iq_full;

  // Top pointer always advances on a call, so a full stack silently overwrites its oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_top_q <= 2'd0;
      ras_cnt_q <= 3'd0;
    end else if (issue_fire) begin
      if (ras_call) begin
        ras_q[ras_top_q + 2'd1] <= pc_plus4;
        ras_top_q               <= ras_top_q + 2'd1;
        ras_cnt_q               <= (ras_cnt_q == 3'd4) ? 3'd4 : ras_cnt_q + 3'd1;
      end else if (ras_ret) begin
        ras_top_q <= ras_top_q - 2'd1;
        ras_cnt_q <= ras_cnt_q - 3'd1;
      end
    end
  end
`endif

  always_comb begin
    next_pc_d   = pc_plus4;
    pred_take_d = 1'b0;
    stall_d     = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        if (q_take) begin
          next_pc_d   = pc_q + imm_b;
          pred_take_d = 1'b1;
        end
      end
      OP_JAL: begin
        next_pc_d   = pc_q + imm_j;
        pred_take_d = 1'b1;
      end
      OP_JALR: begin
`ifdef FETCH_RAS_EN
        if (ras_ret) begin
          next_pc_d   = ras_q[ras_top_q];
          pred_take_d = 1'b1;
        end else
`endif
        stall_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= 17'd0;
      inst_buf_q <= 32'd0;
      req_vld_q  <= 1'b1;
      push_q     <= 1'b0;
      iq_inst_q  <= 32'd0;
      iq_pc_q    <= 17'd0;
      iq_take_q  <= 1'b0;
      iq_pred_q  <= 17'd0;
    end else if (hci_rdy) begin
      push_q <= 1'b0;
      if (redirect_en) begin
        pc_q <= redirect_pc;
        // A request is still in flight unless its response lands this very cycle.
        if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !if_resp_valid) begin
          state_q   <= S_DRAIN;
          req_vld_q <= 1'b0;
        end else begin
          state_q   <= S_REQ;
          req_vld_q <= 1'b1;
        end
      end else begin
        case (state_q)
          S_REQ: begin
            state_q   <= S_WAIT;
            req_vld_q <= 1'b1;
          end
          S_WAIT: begin
            if (if_resp_valid) begin
              inst_buf_q <= if_resp_inst;
              state_q    <= S_ISSUE;
              req_vld_q  <= 1'b0;
            end
          end
          S_ISSUE: begin
            if (!iq_full) begin
              push_q    <= 1'b1;
              iq_inst_q <= inst_buf_q;
              iq_pc_q   <= pc_q;
              iq_take_q <= pred_take_d;
              iq_pred_q <= next_pc_d;
              if (stall_d) begin
                state_q <= S_STALL;
              end else begin
                state_q   <= S_REQ;
                pc_q      <= next_pc_d;
                req_vld_q <= 1'b1;
              end
            end
          end
          S_STALL: ;
          S_DRAIN: begin
            if (if_resp_valid) begin
              state_q   <= S_REQ;
              req_vld_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= S_REQ;
            req_vld_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign if_req_valid = req_vld_q;
  assign if_req_addr  = pc_q;
  assign q_address    = pc_q;
  // The strobe is held back, not lost, while the pipeline is frozen.
  assign iq_push      = push_q & hci_rdy;
  assign iq_inst      = iq_inst_q;
  assign iq_pc        = iq_pc_q;
  assign iq_pred_take = iq_take_q;
  assign iq_pred_pc   = iq_pred_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized instruction streams.
// Expectations come from a transaction-level model (immediates as integers, RAS as a queue under FETCH_RAS_EN).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        hci_rdy;
  logic        if_req_valid;
  logic [16:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic [16:0] q_address;
  logic        q_take;
  logic        iq_full;
  logic        iq_push;
  logic [31:0] iq_inst;
  logic [16:0] iq_pc;
  logic        iq_pred_take;
  logic [16:0] iq_pred_pc;
  logic        redirect_en;
  logic [16:0] redirect_pc;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] mpc;
  logic [16:0] ras [$];

  localparam int K_ALU  = 0;
  localparam int K_BR   = 1;
  localparam int K_JAL  = 2;
  localparam int K_JALR = 3;
  localparam int K_RET  = 4;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .hci_rdy(hci_rdy),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
    .q_address(q_address), .q_take(q_take),
    .iq_full(iq_full), .iq_push(iq_push), .iq_inst(iq_inst), .iq_pc(iq_pc),
    .iq_pred_take(iq_pred_take), .iq_pred_pc(iq_pred_pc),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] wrap(input int v);
    logic [31:0] t;
    t = v;
    return t[16:0];
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input int rd, input int rs1, input int imm);
    logic [31:0] t;
    logic [31:0] r;
    logic [31:0] s;
    t = imm; r = rd; s = rs1;
    return {t[11:0], s[4:0], 3'b000, r[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_b(input int imm);
    logic [31:0] i;
    i = imm;
    return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] i;
    logic [31:0] r;
    i = imm; r = rd;
    return {i[20], i[10:1], i[11], i[19:12], r[4:0], 7'b1101111};
  endfunction

`ifdef FETCH_RAS_EN
  function automatic bit is_link(input int r);
    return (r == 1) || (r == 5);
  endfunction

  task automatic ras_call(input logic [16:0] ret);
    ras.push_back(ret);
    if (ras.size() > 4) void'(ras.pop_front());
  endtask
`endif

  // Entry: DUT presenting the request for mpc. Exit: push checked, DUT in REQ for the next pc or in STALL.
  task automatic fetch_one(input logic [31:0] inst, input int lat, input int nfull, input logic take,
                           input logic etake, input logic [16:0] enext, input logic estall, input string tag);
    chk({tag, ".req_v"}, if_req_valid, 1);
    chk({tag, ".req_a"}, if_req_addr, mpc);
    step();
    chk({tag, ".push_once"}, iq_push, 0);
    for (int k = 0; k < lat; k++) begin
      chk({tag, ".wait_a"}, if_req_addr, mpc);
      step();
    end
    chk({tag, ".wait_v"}, if_req_valid, 1);
    if_resp_valid = 1'b1;
    if_resp_inst  = inst;
    step();
    if_resp_valid = 1'b0;
    if_resp_inst  = $urandom;
    chk({tag, ".issue_v"}, if_req_valid, 0);
    chk({tag, ".q_addr"}, q_address, mpc);
    for (int k = 0; k < nfull; k++) begin
      iq_full = 1'b1;
      q_take  = 1'($urandom_range(0, 1));
      step();
      chk({tag, ".full_push"}, iq_push, 0);
    end
    iq_full = 1'b0;
    q_take  = take;
    step();
    q_take = 1'b0;
    chk({tag, ".push"}, iq_push, 1);
    chk({tag, ".inst"}, iq_inst, inst);
    chk({tag, ".pc"}, iq_pc, mpc);
    chk({tag, ".take"}, iq_pred_take, etake);
    chk({tag, ".pred"}, iq_pred_pc, enext);
    if (estall) begin
      chk({tag, ".stall_v"}, if_req_valid, 0);
    end else begin
      mpc = enext;
      chk({tag, ".next_a"}, if_req_addr, mpc);
    end
  endtask

  task automatic release_stall(input logic [16:0] rpc, input string tag);
    for (int k = 0; k < 3; k++) begin
      step();
      chk({tag, ".stall_req"}, if_req_valid, 0);
      chk({tag, ".stall_push"}, iq_push, 0);
    end
    redirect_en = 1'b1;
    redirect_pc = rpc;
    step();
    redirect_en = 1'b0;
    mpc = rpc;
    chk({tag, ".resume_v"}, if_req_valid, 1);
    chk({tag, ".resume_a"}, if_req_addr, mpc);
  endtask

  task automatic go(input logic [16:0] pc, input string tag);
    redirect_en = 1'b1;
    redirect_pc = pc;
    step();
    redirect_en = 1'b0;
    mpc = pc;
    chk({tag, ".go_a"}, if_req_addr, mpc);
  endtask

  task automatic exec(input int kind, input int imm, input int rd, input int rs1, input logic take,
                      input int lat, input int nfull, input logic [16:0] rpc, input string tag);
    logic [31:0] inst;
    logic        etake;
    logic        estall;
    logic [16:0] enext;
    logic [16:0] p4;
    etake  = 1'b0;
    estall = 1'b0;
    p4     = wrap(int'(mpc) + 4);
    enext  = p4;
    case (kind)
      K_BR: begin
        inst = enc_b(imm);
        if (take) begin
          etake = 1'b1;
          enext = wrap(int'(mpc) + imm);
        end
      end
      K_JAL: begin
        inst  = enc_j(imm, rd);
        etake = 1'b1;
        enext = wrap(int'(mpc) + imm);
`ifdef FETCH_RAS_EN
        if (is_link(rd)) ras_call(p4);
`endif
      end
      K_JALR, K_RET: begin
        inst   = enc_i(7'b1100111, rd, rs1, imm);
        estall = 1'b1;
`ifdef FETCH_RAS_EN
        if (rd == 0 && is_link(rs1) && imm == 0 && ras.size() > 0) begin
          enext  = ras.pop_back();
          etake  = 1'b1;
          estall = 1'b0;
        end else if (is_link(rd)) begin
          ras_call(p4);
        end
`endif
      end
      default: inst = enc_i(7'b0010011, rd, rs1, imm);
    endcase
    fetch_one(inst, lat, nfull, take, etake, enext, estall, tag);
    if (estall) release_stall(rpc, tag);
  endtask

  initial begin
    logic [31:0] r;
    int          kind;
    int          imm;
    int          rd;
    int          rs1;
    rst = 1'b1; hci_rdy = 1'b1; if_resp_valid = 1'b0; if_resp_inst = 32'd0;
    q_take = 1'b0; iq_full = 1'b0; redirect_en = 1'b0; redirect_pc = 17'd0;
    step(); step(); step();
    rst = 1'b0;
    chk("rst.req_v", if_req_valid, 1);
    chk("rst.req_a", if_req_addr, 0);
    chk("rst.q", q_address, 0);
    chk("rst.push", iq_push, 0);
    chk("rst.take", iq_pred_take, 0);
    chk("rst.pred", iq_pred_pc, 0);
    chk("rst.inst", iq_inst, 0);
    chk("rst.pc", iq_pc, 0);
    mpc = 17'd0;

    exec(K_ALU, 5, 3, 0, 1'b0, 1, 0, 17'd0, "addi0");
    go(17'h10, "beq");
    exec(K_BR, -8, 0, 0, 1'b1, 0, 0, 17'd0, "beq_t");
    chk("beq_t.target", if_req_addr, 17'h08);
    go(17'h10, "beq");
    exec(K_BR, -8, 0, 0, 1'b0, 2, 0, 17'd0, "beq_nt");
    chk("beq_nt.target", if_req_addr, 17'h14);
    exec(K_ALU, -1, 7, 7, 1'b1, 0, 3, 17'd0, "full3");

    go(17'h1FFFC, "wrap");
    exec(K_JAL, 8, 0, 0, 1'b0, 0, 0, 17'd0, "jal_wrap");
    chk("jal_wrap.target", if_req_addr, 17'h00004);
    exec(K_JALR, 0, 6, 2, 1'b0, 1, 0, 17'h40, "jalr_stall");

    go(17'h20, "call");
    exec(K_JAL, 'h40, 1, 0, 1'b0, 0, 0, 17'd0, "call");
    exec(K_RET, 0, 0, 1, 1'b0, 0, 0, 17'h24, "ret");
    chk("ret.next", if_req_addr, 17'h24);

    // Redirect while waiting: the late response must be dropped.
    step();
    redirect_en = 1'b1; redirect_pc = 17'h100;
    step();
    redirect_en = 1'b0;
    chk("drain.req_v", if_req_valid, 0);
    chk("drain.q", q_address, 17'h100);
    if_resp_valid = 1'b1; if_resp_inst = enc_j(64, 0);
    step();
    if_resp_valid = 1'b0;
    chk("drain.push", iq_push, 0);
    chk("drain.req_a", if_req_addr, 17'h100);
    mpc = 17'h100;
    exec(K_ALU, 1, 1, 1, 1'b0, 0, 0, 17'd0, "post_drain");

    // Second redirect while draining keeps draining.
    step();
    redirect_en = 1'b1; redirect_pc = 17'h180;
    step();
    redirect_pc = 17'h300;
    step();
    redirect_en = 1'b0;
    chk("drain2.q", q_address, 17'h300);
    step();
    chk("drain2.req_v", if_req_valid, 0);
    if_resp_valid = 1'b1;
    step();
    if_resp_valid = 1'b0;
    chk("drain2.req_a", if_req_addr, 17'h300);
    chk("drain2.push", iq_push, 0);
    mpc = 17'h300;

    // Redirect in ISSUE cancels the push.
    step();
    if_resp_valid = 1'b1; if_resp_inst = enc_i(7'b0010011, 1, 1, 1);
    step();
    if_resp_valid = 1'b0;
    redirect_en = 1'b1; redirect_pc = 17'h400;
    step();
    redirect_en = 1'b0;
    chk("redir_issue.push", iq_push, 0);
    chk("redir_issue.req_a", if_req_addr, 17'h400);
    mpc = 17'h400;

    // hci_rdy low freezes everything, including redirects and the push strobe.
    step();
    hci_rdy = 1'b0; if_resp_valid = 1'b1; if_resp_inst = enc_i(7'b0010011, 2, 2, 9);
    redirect_en = 1'b1; redirect_pc = 17'h1234;
    step(); step();
    chk("frz.req_v", if_req_valid, 1);
    chk("frz.req_a", if_req_addr, 17'h400);
    chk("frz.push", iq_push, 0);
    redirect_en = 1'b0; hci_rdy = 1'b1;
    step();
    if_resp_valid = 1'b0;
    hci_rdy = 1'b0;
    step(); step();
    chk("frz_issue.push", iq_push, 0);
    hci_rdy = 1'b1;
    step();
    hci_rdy = 1'b0;
    #1;
    chk("frz_push.gated", iq_push, 0);
    step();
    chk("frz_push.req_a", if_req_addr, 17'h404);
    hci_rdy = 1'b1;
    #1;
    chk("frz_push.release", iq_push, 1);
    chk("frz_push.inst", iq_inst, enc_i(7'b0010011, 2, 2, 9));
    step();
    chk("frz_push.once", iq_push, 0);
    redirect_en = 1'b1; redirect_pc = 17'h2000; if_resp_valid = 1'b1;
    step();
    redirect_en = 1'b0; if_resp_valid = 1'b0;
    chk("redir_resp.req_a", if_req_addr, 17'h2000);
    chk("redir_resp.push", iq_push, 0);

    // Reset in WAIT overrides hci_rdy and redirect.
    step();
    rst = 1'b1; hci_rdy = 1'b0; redirect_en = 1'b1; redirect_pc = 17'h555;
    step();
    rst = 1'b0; hci_rdy = 1'b1; redirect_en = 1'b0;
    chk("rst2.req_v", if_req_valid, 1);
    chk("rst2.req_a", if_req_addr, 0);
    chk("rst2.pc", iq_pc, 0);
    chk("rst2.pred", iq_pred_pc, 0);
    chk("rst2.inst", iq_inst, 0);
    mpc = 17'd0;
    ras.delete();

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 4);
      rd   = 0;
      rs1  = $urandom_range(0, 31);
      imm  = $urandom_range(0, 4095) - 2048;
      case (kind)
        K_BR:   imm = ($urandom_range(0, 4095) - 2048) * 2;
        K_JAL: begin
          imm = ($urandom_range(0, 1048575) - 524288) * 2;
          rd  = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 1 : 5);
        end
        K_JALR: begin
          case ($urandom_range(0, 3))
            0: rd = 0;
            1: rd = 1;
            2: rd = 5;
            default: rd = 7;
          endcase
          rs1 = ($urandom_range(0, 1) == 0) ? 6 : 5;
          if ($urandom_range(0, 1) == 0) imm = 0;
        end
        K_RET: begin
          rs1 = ($urandom_range(0, 1) == 0) ? 1 : 5;
          imm = 0;
        end
        default: rd = $urandom_range(0, 31);
      endcase
      r = $urandom;
      exec(kind, imm, rd, rs1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2),
           {r[16:2], 2'b00}, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
